// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin fetch/data sharing of one variable-latency memory port with timeout and CPU stall
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int TIMEOUT = 64,
    parameter int CW      = 7
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_valid,
    output logic [31:0]   if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wdata,
    output logic          d_gnt,
    output logic          d_valid,
    output logic [31:0]   d_rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic          mem_ready,
    input  logic [31:0]   mem_rdata,
    output logic          err,
    output logic          stall
);
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;
    localparam logic [CW-1:0] TO = CW'(TIMEOUT);

    state_t        state_q, state_d;
    logic          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          if_gnt_q, if_gnt_d, d_gnt_q, d_gnt_d;
    logic          if_valid_q, if_valid_d, d_valid_q, d_valid_d;
    logic          err_q, err_d, mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d, if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
    logic          i_el, d_el, pick_d, grant, busy, tmo, fin;

    // A port whose valid is high this cycle is dropping its req, so it is never eligible.
    assign i_el    = if_req & ~if_valid_q;
    assign d_el    = d_req & ~d_valid_q;
    assign pick_d  = d_el & (~i_el | ~last_q);
    assign grant   = (state_q == IDLE) & (i_el | d_el);
    assign busy    = (state_q == BUSY_I) | (state_q == BUSY_D);
    assign cnt_inc = cnt_q + 1'b1;
    assign tmo     = (TIMEOUT != 0) & ~mem_ready & (cnt_inc == TO);
    assign fin     = busy & (mem_ready | tmo);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            last_q      <= 1'b0;
            cnt_q       <= '0;
            if_gnt_q    <= 1'b0;
            d_gnt_q     <= 1'b0;
            if_valid_q  <= 1'b0;
            d_valid_q   <= 1'b0;
            err_q       <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            if_gnt_q    <= if_gnt_d;
            d_gnt_q     <= d_gnt_d;
            if_valid_q  <= if_valid_d;
            d_valid_q   <= d_valid_d;
            err_q       <= err_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (grant)
            state_d = pick_d ? BUSY_D : BUSY_I;
        else if (fin)
            state_d = DONE;
        else if (state_q == DONE)
            state_d = IDLE;
    end

    always_comb begin
        last_d      = grant ? pick_d : last_q;
        cnt_d       = grant ? '0 : ((busy & ~mem_ready) ? cnt_inc : cnt_q);
        if_gnt_d    = grant & ~pick_d;
        d_gnt_d     = grant & pick_d;
        mem_req_d   = grant | (mem_req_q & ~fin);
        mem_we_d    = grant ? (pick_d & d_we) : mem_we_q;
        mem_addr_d  = grant ? (pick_d ? d_addr : if_addr) : mem_addr_q;
        mem_wdata_d = (grant & pick_d) ? d_wdata : mem_wdata_q;
        if_valid_d  = fin & (state_q == BUSY_I);
        d_valid_d   = fin & (state_q == BUSY_D);
        err_d       = busy & tmo;
        if_rdata_d  = if_valid_d ? (mem_ready ? mem_rdata : '0) : if_rdata_q;
        // Stores leave the load data untouched; only a timeout clears it.
        d_rdata_d   = d_valid_d ? (mem_ready ? (mem_we_q ? d_rdata_q : mem_rdata) : '0) : d_rdata_q;
    end

    assign if_gnt    = if_gnt_q;
    assign d_gnt     = d_gnt_q;
    assign if_valid  = if_valid_q;
    assign d_valid   = d_valid_q;
    assign err       = err_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign stall     = i_el | d_el;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench with a latency-programmable memory model
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
    logic        if_gnt, if_valid, d_gnt, d_valid, mem_req, mem_we, err, stall;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic        mem_ready_m = 1'b0, ready_inj = 1'b0;
    logic [31:0] mem_rdata = '0;

    int          n_cmp = 0, n_bad = 0;
    int          mem_lat = 1, wait_cnt = 0;
    bit          mem_mute = 1'b0;
    logic [31:0] mem [logic [31:0]];
    logic [31:0] exp_i[$], exp_d[$];
    bit          exp_g[$];
    logic [31:0] last_d = '0;

    mem_port_arbiter #(.AW(32), .TIMEOUT(4), .CW(7)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready_m | ready_inj), .mem_rdata(mem_rdata),
        .err(err), .stall(stall)
    );

    always #5 clk = ~clk;

    // Memory answers mem_lat cycles into a request unless muted.
    always @(negedge clk) begin
        mem_ready_m = 1'b0;
        if (reset || !mem_req) wait_cnt = 0;
        else begin
            wait_cnt++;
            if (!mem_mute && wait_cnt == mem_lat) begin
                mem_ready_m = 1'b1;
                if (mem_we) mem[mem_addr] = mem_wdata;
                else mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
            end
        end
    end

    task automatic reset_pulse;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_valid(input bit dp, output int cyc, output int hi);
        cyc = -1;
        hi = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (dp ? d_valid : if_valid) begin
                cyc = k;
                break;
            end
            if (mem_req) hi++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({if_gnt, if_valid, d_gnt, d_valid, err, mem_req, mem_we} !== 7'b0) begin
            n_bad++; $display("FAIL reset_ctl: got %b want 0", {if_gnt, if_valid, d_gnt, d_valid, err, mem_req, mem_we});
        end
        n_cmp++;
        if ({mem_addr, mem_wdata, if_rdata, d_rdata} !== 128'h0) begin
            n_bad++; $display("FAIL reset_data: got %h want 0", {mem_addr, mem_wdata, if_rdata, d_rdata});
        end
        if_req = 1'b1;
        #1;
        n_cmp++;
        if (stall !== 1'b1) begin n_bad++; $display("FAIL reset_stall: got %b want 1", stall); end
        if_req = 1'b0;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_simultaneous;
        int i_done = 0, d_done = 0;
        bit i_re = 0, d_re = 0, g;
        logic [31:0] e;
        reset_pulse();
        mem_lat = 1;
        mem[32'h200] = 32'h11111111;
        mem[32'h300] = 32'h22222222;
        repeat (2) begin exp_i.push_back(32'h11111111); exp_d.push_back(32'h22222222); end
        exp_g.push_back(1); exp_g.push_back(0); exp_g.push_back(1); exp_g.push_back(0);
        if_addr = 32'h200; d_addr = 32'h300; d_we = 1'b0;
        if_req = 1'b1; d_req = 1'b1;
        for (int k = 0; k < 100 && (i_done < 2 || d_done < 2); k++) begin
            @(negedge clk);
            if (i_re) begin if_req = 1'b1; i_re = 0; end
            if (d_re) begin d_req = 1'b1; d_re = 0; end
            if (if_gnt || d_gnt) begin
                n_cmp++;
                g = exp_g.size() != 0 ? exp_g.pop_front() : ~d_gnt;
                if ((if_gnt && d_gnt) || d_gnt !== g) begin
                    n_bad++; $display("FAIL rr_order: got d_gnt=%b if_gnt=%b want d_gnt=%b", d_gnt, if_gnt, g);
                end
            end
            if (if_valid) begin
                n_cmp++;
                e = exp_i.size() != 0 ? exp_i.pop_front() : 32'hxxxxxxxx;
                if (if_rdata !== e) begin n_bad++; $display("FAIL rr_if_rdata: got %h want %h", if_rdata, e); end
                if_req = 1'b0; i_done++; i_re = i_done < 2;
            end
            if (d_valid) begin
                n_cmp++;
                e = exp_d.size() != 0 ? exp_d.pop_front() : 32'hxxxxxxxx;
                if (d_rdata !== e) begin n_bad++; $display("FAIL rr_d_rdata: got %h want %h", d_rdata, e); end
                last_d = e;
                d_req = 1'b0; d_done++; d_re = d_done < 2;
            end
        end
        n_cmp++;
        if (i_done != 2 || d_done != 2 || exp_g.size() != 0) begin
            n_bad++; $display("FAIL rr_complete: got i=%0d d=%0d grants_left=%0d want 2 2 0", i_done, d_done, exp_g.size());
        end
        if_req = 1'b0; d_req = 1'b0;
        exp_g.delete(); exp_i.delete(); exp_d.delete();
        @(negedge clk);
    endtask

    task automatic test_fetch;
        int cyc = -1, stall_low = 0;
        logic [31:0] e;
        mem_lat = 3;
        mem[32'h40] = 32'h8C220004;
        exp_i.push_back(32'h8C220004);
        if_addr = 32'h40; if_req = 1'b1;
        #1;
        n_cmp++;
        if (stall !== 1'b1) begin n_bad++; $display("FAIL fetch_stall_req: got %b want 1", stall); end
        @(negedge clk);
        n_cmp++;
        if ({if_gnt, d_gnt, mem_req, mem_we} !== 4'b1010 || mem_addr !== 32'h40) begin
            n_bad++; $display("FAIL fetch_grant: got gnt/req/we=%b addr=%h want 1010 00000040", {if_gnt, d_gnt, mem_req, mem_we}, mem_addr);
        end
        if (!stall) stall_low++;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            if (if_valid) begin cyc = k; break; end
            if (!stall) stall_low++;
        end
        n_cmp++;
        if (cyc !== 3) begin n_bad++; $display("FAIL fetch_latency: got %0d want 3", cyc); end
        n_cmp++;
        if (stall_low !== 0) begin n_bad++; $display("FAIL fetch_stall_hold: got %0d low cycles want 0", stall_low); end
        e = exp_i.pop_front();
        n_cmp++;
        if (if_valid !== 1'b1 || if_rdata !== e || err !== 1'b0) begin
            n_bad++; $display("FAIL fetch_data: got valid=%b rdata=%h err=%b want 1 %h 0", if_valid, if_rdata, err, e);
        end
        if_req = 1'b0;
        #1;
        n_cmp++;
        if (stall !== 1'b0) begin n_bad++; $display("FAIL fetch_stall_end: got %b want 0", stall); end
        @(negedge clk);
    endtask

    task automatic test_store_load;
        int cyc, hi, gap = 0;
        logic [31:0] e;
        mem_lat = 2;
        d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF; d_req = 1'b1;
        exp_d.push_back(last_d);
        @(negedge clk);
        n_cmp++;
        if ({d_gnt, mem_req, mem_we} !== 3'b111 || mem_addr !== 32'h100 || mem_wdata !== 32'hDEADBEEF) begin
            n_bad++; $display("FAIL store_grant: got gnt/req/we=%b addr=%h wdata=%h want 111 00000100 deadbeef", {d_gnt, mem_req, mem_we}, mem_addr, mem_wdata);
        end
        wait_valid(1, cyc, hi);
        e = exp_d.pop_front();
        n_cmp++;
        if (cyc < 0 || d_rdata !== e || err !== 1'b0) begin
            n_bad++; $display("FAIL store_done: got cyc=%0d rdata=%h err=%b want rdata %h err 0", cyc, d_rdata, err, e);
        end
        if (!mem_req) gap++;
        d_req = 1'b0;
        @(negedge clk);
        if (!mem_req) gap++;
        d_we = 1'b0; d_req = 1'b1;
        exp_d.push_back(32'hDEADBEEF);
        @(negedge clk);
        n_cmp++;
        if (gap < 2 || {d_gnt, mem_req, mem_we} !== 3'b110) begin
            n_bad++; $display("FAIL load_grant: got gap=%0d gnt/req/we=%b want >=2 110", gap, {d_gnt, mem_req, mem_we});
        end
        wait_valid(1, cyc, hi);
        e = exp_d.pop_front();
        n_cmp++;
        if (cyc < 0 || d_rdata !== e) begin n_bad++; $display("FAIL load_data: got cyc=%0d rdata=%h want %h", cyc, d_rdata, e); end
        last_d = e;
        d_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_timeout;
        int cyc, hi;
        logic [31:0] e;
        mem_mute = 1'b1;
        d_we = 1'b0; d_addr = 32'h300; d_req = 1'b1;
        exp_d.push_back(32'h0);
        @(negedge clk);
        n_cmp++;
        if (d_gnt !== 1'b1) begin n_bad++; $display("FAIL tmo_grant: got %b want 1", d_gnt); end
        wait_valid(1, cyc, hi);
        n_cmp++;
        if (cyc !== 4 || 1 + hi !== 4) begin n_bad++; $display("FAIL tmo_req_cycles: got cyc=%0d req_cycles=%0d want 4 4", cyc, 1 + hi); end
        e = exp_d.pop_front();
        n_cmp++;
        if ({d_valid, err, mem_req} !== 3'b110 || d_rdata !== e) begin
            n_bad++; $display("FAIL tmo_abort: got valid/err/req=%b rdata=%h want 110 %h", {d_valid, err, mem_req}, d_rdata, e);
        end
        last_d = e;
        d_req = 1'b0; mem_mute = 1'b0;
        @(negedge clk);
        mem_lat = 2;
        mem[32'h44] = 32'h12345678;
        exp_i.push_back(32'h12345678);
        if_addr = 32'h44; if_req = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (if_gnt !== 1'b1) begin n_bad++; $display("FAIL tmo_next_grant: got %b want 1", if_gnt); end
        wait_valid(0, cyc, hi);
        e = exp_i.pop_front();
        n_cmp++;
        if (cyc < 0 || if_rdata !== e || err !== 1'b0) begin
            n_bad++; $display("FAIL tmo_next_fetch: got cyc=%0d rdata=%h err=%b want %h 0", cyc, if_rdata, err, e);
        end
        if_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_tie;
        int cyc, hi;
        logic [31:0] e;
        mem_lat = 4;
        d_we = 1'b0; d_addr = 32'h100; d_req = 1'b1;
        exp_d.push_back(32'hDEADBEEF);
        @(negedge clk);
        wait_valid(1, cyc, hi);
        e = exp_d.pop_front();
        n_cmp++;
        if (cyc !== 4 || err !== 1'b0 || d_rdata !== e) begin
            n_bad++; $display("FAIL tie_ready_wins: got cyc=%0d err=%b rdata=%h want 4 0 %h", cyc, err, d_rdata, e);
        end
        last_d = e;
        d_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int spurious = 0;
        mem_mute = 1'b1;
        d_we = 1'b0; d_addr = 32'h100; d_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (mem_req !== 1'b1) begin n_bad++; $display("FAIL rst_mid_pre: got mem_req=%b want 1", mem_req); end
        reset = 1'b1; d_req = 1'b0;
        #1;
        n_cmp++;
        if ({mem_req, d_gnt, d_valid, err} !== 4'b0 || d_rdata !== 32'h0) begin
            n_bad++; $display("FAIL rst_mid_drop: got req/gnt/valid/err=%b rdata=%h want 0000 0", {mem_req, d_gnt, d_valid, err}, d_rdata);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        ready_inj = 1'b1;
        @(negedge clk);
        ready_inj = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (d_valid || if_valid || err || mem_req) spurious++;
        end
        n_cmp++;
        if (spurious !== 0) begin n_bad++; $display("FAIL rst_mid_ready_ignored: got %0d active cycles want 0", spurious); end
        mem_mute = 1'b0;
    endtask

    initial begin
        test_reset();
        test_simultaneous();
        test_fetch();
        test_store_load();
        test_timeout();
        test_tie();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before 200000");
        $fatal(1);
    end
endmodule
